// File: rtl/ddma_pkg.sv
// ddma_pkg: shared types and widths for the packet DMA engine.
package ddma_pkg;
  typedef enum logic [2:0] {IDLE, RD, TX, RX, DONE} state_t;
  typedef enum logic {OP_SEND = 1'b0, OP_RECV = 1'b1} op_t;
  localparam int LEN_W = 16;
  localparam int CNT_W = LEN_W + 1;
endpackage

// File: rtl/ddma_rx_fifo.sv
// ddma_rx_fifo: receive flit FIFO with show-ahead output and wrapping pointers.
module ddma_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt[DEPTH_LOG2];
  assign do_pop = pop & ~empty;
  // a pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + DEPTH_LOG2'(1);
      end
      if (do_pop) rp <= rp + DEPTH_LOG2'(1);
      cnt <= cnt + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/ddma.sv
// ddma: packet DMA between a NoC local port and a scratchpad; SEND streams memory out, RECV stores one packet.
// Define DDMA_IRQ_EN for a sticky interrupt; otherwise irq is tied low and the CPU polls done.
module ddma
  import ddma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx_i,
  input  logic [FLIT_WIDTH-1:0]       data_i,
  output logic                        credit_o,
  output logic                        tx_o,
  output logic [FLIT_WIDTH-1:0]       data_o,
  input  logic                        credit_i,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [MEMORY_BUS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  output logic                        done,
  output logic                        truncated,
  output logic                        irq
);
  if (FLIT_WIDTH != MEMORY_BUS_WIDTH) begin : g_width_check
    $error("ddma: FLIT_WIDTH must equal MEMORY_BUS_WIDTH");
  end
  state_t state, nxt;
  op_t op;
  logic [MEMORY_BUS_WIDTH-1:0] addr;
  logic [LEN_W-1:0] len, rem;
  logic [CNT_W-1:0] cnt;
  logic [FLIT_WIDTH-1:0] data_r, fifo_dout;
  logic ld, trunc, fifo_full, fifo_empty, pop, accept, rx_last;
  ddma_rx_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(rx_i & credit_o),
    .pop(pop),
    .din(data_i),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign credit_o = ~fifo_full;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign done = state == DONE;
  assign truncated = done & (op == OP_RECV) & trunc;
  // read data arrives during the first TX cycle; present it directly, then hold it
  assign data_o = ld ? mem_rdata : data_r;
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    pop = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    tx_o = 1'b0;
    rx_last = 1'b0;
    case (state)
      IDLE: if (accept) nxt = (cmd_op == OP_RECV) ? RX : (cmd_len == '0) ? DONE : RD;
      RD: begin
        mem_en = 1'b1;
        mem_addr = addr + MEMORY_BUS_WIDTH'(cnt);
        nxt = TX;
      end
      TX: begin
        tx_o = 1'b1;
        if (credit_i) nxt = (cnt + CNT_W'(1) == {1'b0, len}) ? DONE : RD;
      end
      RX: begin
        pop = ~fifo_empty;
        mem_en = pop & (cnt < {1'b0, len});
        mem_we = mem_en;
        mem_addr = mem_en ? addr + MEMORY_BUS_WIDTH'(cnt) : '0;
        mem_wdata = mem_en ? fifo_dout : '0;
        rx_last = pop & ((cnt == CNT_W'(1)) ? (fifo_dout[LEN_W-1:0] == '0)
                                            : (cnt > CNT_W'(1)) & (rem == LEN_W'(1)));
        if (rx_last) nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      op <= OP_SEND;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      rem <= '0;
      ld <= 1'b0;
      data_r <= '0;
      trunc <= 1'b0;
    end else begin
      ld <= state == RD;
      if (ld) data_r <= mem_rdata;
      if (accept) begin
        op <= op_t'(cmd_op);
        addr <= cmd_addr;
        len <= cmd_len;
        cnt <= '0;
        trunc <= 1'b0;
      end
      if (tx_o & credit_i) cnt <= cnt + CNT_W'(1);
      if (pop) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt >= {1'b0, len}) trunc <= 1'b1;
        if (cnt == CNT_W'(1)) rem <= fifo_dout[LEN_W-1:0];
        else if (cnt > CNT_W'(1)) rem <= rem - LEN_W'(1);
      end
    end
  end
`ifdef DDMA_IRQ_EN
  logic irq_r;
  // sticky: raised on completion or on a packet waiting while idle, cleared by the next command
  always_ff @(posedge clock)
    irq_r <= reset ? 1'b0 : accept ? 1'b0 : (done | (state == IDLE & ~fifo_empty)) ? 1'b1 : irq_r;
  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_ddma.sv
// tb_ddma: directed self-checking bench for ddma with a synchronous scratchpad model.
module tb_ddma;
  logic clock = 1'b0;
  logic reset, rx_i, credit_o, tx_o, credit_i, mem_en, mem_we;
  logic cmd_valid, cmd_ready, cmd_op, done, truncated, irq;
  logic [31:0] data_i, data_o, mem_addr, mem_wdata, mem_rdata, cmd_addr;
  logic [15:0] cmd_len;
  logic pl_en;
  logic [7:0] pl_a;
  logic [31:0] pl_d;
  logic [31:0] mem [256];
  logic [31:0] sent [16];
  int nsent = 0;
  int checks = 0;
  int errors = 0;
`ifdef DDMA_IRQ_EN
  localparam logic [31:0] IRQ_EXP = 32'd1;
`else
  localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

  ddma dut (
    .clock(clock), .reset(reset), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
    .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .done(done), .truncated(truncated), .irq(irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  always @(posedge clock)
    if (tx_o && credit_i && nsent < 16) begin
      sent[nsent] <= data_o;
      nsent <= nsent + 1;
    end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; rx_i = 0; data_i = 0; credit_i = 1; cmd_valid = 0; cmd_op = 0;
    cmd_addr = 0; cmd_len = 0; pl_en = 0; pl_a = 0; pl_d = 0;
    tick;
    chk("rst_tx", 32'(tx_o), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trunc", 32'(truncated), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_credit", 32'(credit_o), 1);
    pl_en = 1;
    for (int i = 0; i < 3; i++) begin
      pl_a = 8'(16 + i);
      pl_d = 32'(10 + i);
      tick;
    end
    pl_a = 8'h84; pl_d = 32'h5555; tick;
    pl_en = 0; reset = 0; tick;

    // SEND three words, no backpressure
    cmd_valid = 1; cmd_op = 0; cmd_addr = 32'h10; cmd_len = 16'd3; tick; cmd_valid = 0;
    chk("rd0_en", 32'(mem_en), 1);
    chk("rd0_we", 32'(mem_we), 0);
    chk("rd0_addr", mem_addr, 32'h10);
    chk("busy_ready", 32'(cmd_ready), 0);
    tick;
    chk("tx0_valid", 32'(tx_o), 1);
    chk("tx0_data", data_o, 32'hA);
    tick;
    chk("rd1_tx", 32'(tx_o), 0);
    chk("rd1_addr", mem_addr, 32'h11);
    tick; chk("tx1_data", data_o, 32'hB);
    tick; tick; chk("tx2_data", data_o, 32'hC);
    tick;
    chk("send_done", 32'(done), 1);
    chk("send_trunc", 32'(truncated), 0);
    tick;
    chk("done_pulse", 32'(done), 0);
    chk("send_irq", 32'(irq), IRQ_EXP);
    chk("idle_ready", 32'(cmd_ready), 1);
    chk("sent_n1", 32'(nsent), 3);

    // SEND with a stall on the second flit
    cmd_valid = 1; tick; cmd_valid = 0;
    chk("irq_clear", 32'(irq), 0);
    tick; chk("bp_tx0", data_o, 32'hA);
    tick; credit_i = 0;
    tick;
    chk("bp_hold_first", data_o, 32'hB);
    cmd_valid = 1; cmd_op = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_tx", 32'(tx_o), 1);
      chk("bp_hold_data", data_o, 32'hB);
      chk("bp_ready", 32'(cmd_ready), 0);
    end
    credit_i = 1; cmd_valid = 0; cmd_op = 0;
    tick;
    chk("bp_rd2_tx", 32'(tx_o), 0);
    chk("bp_rd2_addr", mem_addr, 32'h12);
    tick; chk("bp_tx2", data_o, 32'hC);
    tick; chk("bp_done", 32'(done), 1);
    tick;
    chk("sent_n2", 32'(nsent), 6);
    chk("sent3", sent[3], 32'hA);
    chk("sent4", sent[4], 32'hB);
    chk("sent5", sent[5], 32'hC);

    // SEND of zero length completes without memory access
    cmd_valid = 1; cmd_len = 0; tick; cmd_valid = 0;
    chk("len0_done", 32'(done), 1);
    chk("len0_mem", 32'(mem_en), 0);
    tick;
    chk("len0_sent", 32'(nsent), 6);

    // RECV a four-flit packet
    rx_i = 1;
    data_i = 32'h0101; tick;
    data_i = 32'd2; tick;
    data_i = 32'hD1; tick;
    data_i = 32'hD2; tick;
    rx_i = 0;
    cmd_valid = 1; cmd_op = 1; cmd_addr = 32'h40; cmd_len = 16'd8; tick; cmd_valid = 0;
    chk("rx_we", 32'(mem_we), 1);
    chk("rx_addr0", mem_addr, 32'h40);
    chk("rx_wdata0", mem_wdata, 32'h0101);
    tick; tick; tick; tick;
    chk("rx_done", 32'(done), 1);
    chk("rx_trunc", 32'(truncated), 0);
    chk("rx_m40", mem[8'h40], 32'h0101);
    chk("rx_m41", mem[8'h41], 32'd2);
    chk("rx_m42", mem[8'h42], 32'hD1);
    chk("rx_m43", mem[8'h43], 32'hD2);
    tick;

    // RECV truncation: eight-flit packet into a four-word buffer
    rx_i = 1;
    data_i = 32'h0202; tick;
    data_i = 32'd6; tick;
    for (int i = 0; i < 6; i++) begin
      data_i = 32'(224 + i);
      tick;
    end
    rx_i = 0;
    chk("tr_full", 32'(credit_o), 0);
    cmd_valid = 1; cmd_addr = 32'h80; cmd_len = 16'd4; tick; cmd_valid = 0;
    chk("tr_addr0", mem_addr, 32'h80);
    tick; tick; tick; tick;
    chk("tr_discard_en", 32'(mem_en), 0);
    chk("tr_credit", 32'(credit_o), 1);
    chk("tr_not_done", 32'(done), 0);
    tick; tick; tick; tick;
    chk("tr_done", 32'(done), 1);
    chk("tr_trunc", 32'(truncated), 1);
    chk("tr_m80", mem[8'h80], 32'h0202);
    chk("tr_m81", mem[8'h81], 32'd6);
    chk("tr_m82", mem[8'h82], 32'hE0);
    chk("tr_m83", mem[8'h83], 32'hE1);
    chk("tr_m84", mem[8'h84], 32'h5555);
    tick;

    // FIFO full: ten flits offered, eight accepted
    rx_i = 1;
    for (int i = 0; i < 10; i++) begin
      data_i = (i == 0) ? 32'h0303 : (i == 1) ? 32'd6 : 32'(240 + i - 2);
      tick;
      chk("ff_credit", 32'(credit_o), (i < 7) ? 32'd1 : 32'd0);
    end
    rx_i = 0;
    chk("ff_pending_irq", 32'(irq), IRQ_EXP);
    cmd_valid = 1; cmd_addr = 32'hA0; cmd_len = 16'd8; tick; cmd_valid = 0;
    for (int i = 0; i < 8; i++) tick;
    chk("ff_done", 32'(done), 1);
    chk("ff_trunc", 32'(truncated), 0);
    chk("ff_credit_after", 32'(credit_o), 1);
    chk("ff_mA0", mem[8'hA0], 32'h0303);
    chk("ff_mA1", mem[8'hA1], 32'd6);
    for (int i = 0; i < 6; i++) chk("ff_data", mem[8'(162 + i)], 32'(240 + i));
    tick;

    // reset during TX aborts and empties the FIFO
    rx_i = 1; data_i = 32'h77; tick; rx_i = 0;
    cmd_valid = 1; cmd_op = 0; cmd_addr = 32'h10; cmd_len = 16'd3; tick; cmd_valid = 0;
    tick;
    chk("ab_tx", 32'(tx_o), 1);
    reset = 1; tick;
    chk("ab_tx_off", 32'(tx_o), 0);
    chk("ab_ready", 32'(cmd_ready), 1);
    chk("ab_done", 32'(done), 0);
    chk("ab_irq", 32'(irq), 0);
    chk("ab_data_o", data_o, 0);
    reset = 0; tick;
    chk("ab_done2", 32'(done), 0);
    cmd_valid = 1; cmd_op = 1; cmd_addr = 32'hC0; cmd_len = 16'd4; tick; cmd_valid = 0;
    chk("ab_empty0", 32'(mem_en), 0);
    tick;
    chk("ab_empty1", 32'(mem_en), 0);
    chk("ab_irq2", 32'(irq), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
